logic_eval_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one registered evaluator of y = (a & b) | c between NUM_REQ requesters. Each requester offers an {a,b,c} operand triple over a valid/ready handshake. The block grants one requester, evaluates the triple, and returns the result tagged with the requester index on a single response channel. It sits between the operand producers and the one shared logic-evaluation resource.

---
 rtl/logic_eval_rr_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_logic_eval_rr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_rr_arbiter.sv
// Round-robin arbiter that shares one registered (a & b) | c evaluator among NUM_REQ requesters.
// Define LOGIC_EVAL_STATS_EN to add the saturating served_cnt response counter.
module logic_eval_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_y,
    output logic [ID_W-1:0]    rsp_id,
    output logic               busy
`ifdef LOGIC_EVAL_STATS_EN
    ,
    output logic [15:0]        served_cnt
`endif
);

    localparam int SLOTS = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              cap_a_q, cap_a_d;
    logic              cap_b_q, cap_b_d;
    logic              cap_c_q, cap_c_d;
    logic [ID_W-1:0]   cap_id_q, cap_id_d;
    logic              rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [SLOTS-1:0]  valid_pad;
    logic [SLOTS-1:0]  a_pad;
    logic [SLOTS-1:0]  b_pad;
    logic [SLOTS-1:0]  c_pad;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W:0]     scan_sum;
    logic              idle;
    logic              grant;
    logic              rsp_hs;

    // Pad request vectors out to a power of two so an ID_W-bit index always lands in range.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_real
                assign valid_pad[gi] = req_valid[gi];
                assign a_pad[gi]     = req_a[gi];
                assign b_pad[gi]     = req_b[gi];
                assign c_pad[gi]     = req_c[gi];
            end else begin : g_empty
                assign valid_pad[gi] = 1'b0;
                assign a_pad[gi]     = 1'b0;
                assign b_pad[gi]     = 1'b0;
                assign c_pad[gi]     = 1'b0;
            end
        end
    endgenerate

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            if (valid_pad[scan_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    assign idle   = (state_q == IDLE);
    assign grant  = idle && win_found;
    assign rsp_hs = (state_q == RESP) && rsp_ready;

    // The grant is gated by rst_n so req_ready is low while reset is held, even with requests pending.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && grant && (win_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cap_a_d  = cap_a_q;
        cap_b_d  = cap_b_q;
        cap_c_d  = cap_c_q;
        cap_id_d = cap_id_q;
        rsp_y_d  = rsp_y_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    cap_a_d  = a_pad[win_idx];
                    cap_b_d  = b_pad[win_idx];
                    cap_c_d  = c_pad[win_idx];
                    cap_id_d = win_idx;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                rsp_y_d  = (cap_a_q & cap_b_q) | cap_c_q;
                rsp_id_d = cap_id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (cap_id_q == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = cap_id_q + ID_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cap_a_q  <= 1'b0;
            cap_b_q  <= 1'b0;
            cap_c_q  <= 1'b0;
            cap_id_q <= '0;
            rsp_y_q  <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cap_a_q  <= cap_a_d;
            cap_b_q  <= cap_b_d;
            cap_c_q  <= cap_c_d;
            cap_id_q <= cap_id_d;
            rsp_y_q  <= rsp_y_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = !idle;

`ifdef LOGIC_EVAL_STATS_EN
    logic [15:0] served_q, served_d;

    always_comb begin
        served_d = served_q;
        if (rsp_hs && (served_q != 16'hFFFF)) begin
            served_d = served_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_q <= 16'd0;
        end else begin
            served_q <= served_d;
        end
    end

    assign served_cnt = served_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_logic_eval_rr_arbiter.sv
// Scoreboard bench for logic_eval_rr_arbiter: a grant model predicts req_ready and pushes the
// expected result; an independent monitor pops and checks every presented response.
module tb_logic_eval_rr_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_a, req_b, req_c, req_ready;
    logic           rsp_valid, rsp_ready, rsp_y, busy;
    logic [IDW-1:0] rsp_id;
`ifdef LOGIC_EVAL_STATS_EN
    logic [15:0]    served_cnt;
`endif

    logic_eval_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef LOGIC_EVAL_STATS_EN
        ,
        .served_cnt(served_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit y;
        int id;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_ptr = 0;
    bit   model_busy = 1'b0;
    int   model_served = 0;
    int   last_grant = -1;
    bit   seen = 1'b0;

    always @(posedge clk) cyc++;

    // Reference model: grant = first valid requester at or after the pointer, modulo N.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int w;
        if (!rst_n) begin
            model_busy <= 1'b0;
            last_grant = -1;
        end else begin
            exp_rdy = '0;
            w = -1;
            if (!model_busy) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (model_ptr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (busy !== model_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, model_busy);
            end
            if (w >= 0) begin
                if (last_grant >= 0) begin
                    checks++;
                    if (cyc - last_grant < 3) begin
                        failures++;
                        $display("FAIL grant_spacing cyc=%0d got=%0d exp>=3", cyc, cyc - last_grant);
                    end
                end
                exp_q.push_back('{y: (req_a[w] & req_b[w]) | req_c[w], id: w, cyc: cyc});
                last_grant = cyc;
                model_busy <= 1'b1;
            end
        end
    end

    // Monitor: compares every presented response with the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            model_ptr <= 0;
            model_served <= 0;
            seen = 1'b0;
        end else begin
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected cyc=%0d got id=%0d y=%b exp=none", cyc, rsp_id, rsp_y);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        checks++;
                        if (cyc - e.cyc != 2) begin
                            failures++;
                            $display("FAIL latency cyc=%0d got=%0d exp=2", cyc, cyc - e.cyc);
                        end
                        seen = 1'b1;
                    end
                    if (rsp_y !== e.y || rsp_id !== IDW'(e.id)) begin
                        failures++;
                        $display("FAIL rsp_data cyc=%0d got id=%0d y=%b exp id=%0d y=%b",
                                 cyc, rsp_id, rsp_y, e.id, e.y);
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        model_ptr <= (e.id + 1) % N;
                        model_busy <= 1'b0;
                        model_served <= model_served + 1;
                    end
                end
            end
`ifdef LOGIC_EVAL_STATS_EN
            checks++;
            if (served_cnt !== 16'(model_served)) begin
                failures++;
                $display("FAIL served_cnt cyc=%0d got=%0d exp=%0d", cyc, served_cnt, model_served);
            end
`endif
        end
    end

    task automatic grab(input bit drop, output int w);
        int got;
        got = -1;
        for (int n = 0; n < 40 && got < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
        end
        checks++;
        if (got < 0) begin
            failures++;
            $display("FAIL grant_timeout cyc=%0d got=none exp=grant", cyc);
        end
        @(posedge clk);
        #1;
        if (drop && got >= 0) begin
            req_valid[got] = 1'b0;
            req_a[got] = ~req_a[got];
            req_b[got] = ~req_b[got];
            req_c[got] = ~req_c[got];
        end
        w = got;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 80 && !ok; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout cyc=%0d got busy=%b exp busy=0", cyc, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rsp_timeout cyc=%0d got rsp_valid=0 exp=1", cyc);
        end
    endtask

    initial begin
        int w;
        logic [N-1:0] g;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || rsp_y !== 1'b0 || rsp_id !== '0) begin
            failures++;
            $display("FAIL reset_values got v=%b busy=%b rdy=%b y=%b id=%0d exp all 0",
                     rsp_valid, busy, req_ready, rsp_y, rsp_id);
        end
        rst_n = 1'b1;

        // Advance the pointer, stall a response, then reset in the middle of it.
        rsp_ready = 1'b1;
        req_valid[2] = 1'b1; req_a[2] = 1'b1; req_b[2] = 1'b0; req_c[2] = 1'b1;
        grab(1'b1, w);
        wait_idle();
        rsp_ready = 1'b0;
        req_valid[3] = 1'b1; req_a[3] = 1'b1; req_b[3] = 1'b1; req_c[3] = 1'b0;
        grab(1'b1, w);
        wait_rsp();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid[3:2] = 2'b11;
        req_a[2] = 1'b0; req_b[2] = 1'b1; req_c[2] = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            failures++;
            $display("FAIL mid_reset got v=%b busy=%b rdy=%b exp 0 0 0", rsp_valid, busy, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        grab(1'b1, w);
        checks++;
        if (w != 2) begin
            failures++;
            $display("FAIL rr_after_reset got=%0d exp=2", w);
        end
        req_valid = '0;
        wait_idle();

        // Single requester, then held continuously.
        req_valid[1] = 1'b1; req_a[1] = 1'b1; req_b[1] = 1'b1; req_c[1] = 1'b0;
        grab(1'b1, w);
        wait_idle();
        req_valid[1] = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // Full truth table through requester 0.
        for (int v = 0; v < 8; v++) begin
            req_a[0] = v[2]; req_b[0] = v[1]; req_c[0] = v[0];
            req_valid[0] = 1'b1;
            grab(1'b1, w);
        end
        wait_idle();

        // Bring the pointer to 0, then all four requesters held.
        req_valid[3] = 1'b1;
        grab(1'b1, w);
        wait_idle();
        req_a = 4'b1010; req_b = 4'b1100; req_c = 4'b0001;
        req_valid = 4'b1111;
        for (int gnum = 0; gnum < 5; gnum++) begin
            grab(1'b0, w);
            checks++;
            if (w != gnum % 4) begin
                failures++;
                $display("FAIL rr_order grant=%0d got=%0d exp=%0d", gnum, w, gnum % 4);
            end
        end
        req_valid = '0;
        wait_idle();

        // Backpressure with a competing request waiting.
        rsp_ready = 1'b0;
        req_valid[2] = 1'b1; req_a[2] = 1'b1; req_b[2] = 1'b1; req_c[2] = 1'b1;
        grab(1'b1, w);
        req_valid[1] = 1'b1; req_a[1] = 1'b0; req_b[1] = 1'b0; req_c[1] = 1'b1;
        wait_rsp();
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL completion got rsp_valid=%b exp=0", rsp_valid);
        end
        grab(1'b1, w);
        wait_idle();

        // Operands flip during EVAL (a 0->1, c 0->1); the captured result must stay 0.
        req_valid[0] = 1'b1; req_a[0] = 1'b0; req_b[0] = 1'b1; req_c[0] = 1'b0;
        grab(1'b1, w);
        wait_idle();

        // Randomized traffic with random backpressure and drops before grant.
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    req_valid[k] = 1'b0;
                    req_a[k] = 1'($urandom_range(0, 1));
                    req_b[k] = 1'($urandom_range(0, 1));
                    req_c[k] = 1'($urandom_range(0, 1));
                end else if (req_valid[k]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[k] = 1'b1;
                    req_a[k] = 1'($urandom_range(0, 1));
                    req_b[k] = 1'($urandom_range(0, 1));
                    req_c[k] = 1'($urandom_range(0, 1));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
